dbus_lsu: RTL

Load/store unit that is the initiator on the core's data bus (DBus), driving the same `rd_en`/`wr_en`/`addr`/`wr_data`/`wr_strobe`/`rd_data` interface that memory-mapped responders (timer, RAM, peripherals) implement. It takes byte-addressed load/store requests from the execute stage and generates byte strobes and store-data alignment. Misaligned accesses that cross a word boundary are split into two sequential word accesses. Load data is merged and sign- or zero-extended before a single-cycle response returns to the core.

---
 rtl/rv32.sv | 6 +
 rtl/saratoga.sv | 17 +
 rtl/lsu_align.sv | 45 ++++
 rtl/dbus_lsu.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rv32.sv
// Shared RV32 datapath types.
package rv32;

  typedef logic [31:0] word;

endpackage

// File: rtl/saratoga.sv
// Core-wide types for the saratoga load/store path.
package saratoga;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10
  } lsu_size_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAcc0 = 2'b01,
    StAcc1 = 2'b10,
    StResp = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the LSU: strobe mask, store-data shift, load merge and extension.
module lsu_align
  import saratoga::*;
(
  input  lsu_size_t   size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  rv32::word   st_data,
  input  logic [63:0] ld_raw,
  output logic [7:0]  mask,
  output logic [63:0] st_aligned,
  output rv32::word   ld_result
);

  logic [7:0] base_mask;
  rv32::word  data_mask;
  rv32::word  shifted;

  always_comb begin
    base_mask = 8'h00;
    data_mask = '0;
    unique case (size)
      LSU_BYTE: begin base_mask = 8'h01; data_mask = 32'h0000_00ff; end
      LSU_HALF: begin base_mask = 8'h03; data_mask = 32'h0000_ffff; end
      LSU_WORD: begin base_mask = 8'h0f; data_mask = 32'hffff_ffff; end
      default:  ;
    endcase
  end

  assign mask       = base_mask << offset;
  assign st_aligned = {32'b0, st_data & data_mask} << {offset, 3'b000};
  // Bytes above the access width fall out of the 32-bit window or are masked below.
  assign shifted    = 32'(ld_raw >> {offset, 3'b000});

  always_comb begin
    ld_result = '0;
    unique case (size)
      LSU_BYTE: ld_result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      LSU_HALF: ld_result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      LSU_WORD: ld_result = shifted;
      default:  ;
    endcase
  end

endmodule

// File: rtl/dbus_lsu.sv
// Data-bus load/store unit: one request at a time, word-boundary crossings split into two
// bus cycles, single-cycle response back to the core.
module dbus_lsu
  import saratoga::*;
#(
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  rv32::word         req_wdata,
  output logic              resp_valid,
  output rv32::word         resp_rdata,
  output logic              resp_err,
  output logic              rd_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output rv32::word         wr_data,
  output logic [3:0]        wr_strobe,
  input  rv32::word         rd_data
);

  lsu_state_t  state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [31:0] addr_q;
  lsu_size_t   size_q;
  rv32::word   wdata_q, lo_q, hi_q;

  logic [7:0]        mask;
  logic [63:0]       st_aligned;
  rv32::word         ld_result;
  logic              split;
  logic [ADDR_W-1:0] word_addr;

  lsu_align u_align (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_raw      ({hi_q, lo_q}),
    .mask        (mask),
    .st_aligned  (st_aligned),
    .ld_result   (ld_result)
  );

  assign split     = |mask[7:4];
  assign word_addr = addr_q[ADDR_W+1:2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = (req_size == 2'b11) ? StResp : StAcc0;
      StAcc0: state_d = split ? StAcc1 : StResp;
      StAcc1: state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == StIdle && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      size_q  <= lsu_size_t'(req_size);
      uns_q   <= req_unsigned;
      wdata_q <= req_wdata;
      err_q   <= (req_size == 2'b11);
    end
    if (!rst && state_q == StAcc0) lo_q <= rd_data;
    if (!rst && state_q == StAcc1) hi_q <= rd_data;
  end

  // Outputs decode only from registered state; reset forces everything low immediately.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    addr       = '0;
    wr_data    = '0;
    wr_strobe  = 4'b0000;
    if (!rst) begin
      unique case (state_q)
        StIdle: req_ready = 1'b1;
        StAcc0: begin
          rd_en     = ~we_q;
          wr_en     = we_q;
          addr      = word_addr;
          wr_data   = st_aligned[31:0];
          wr_strobe = we_q ? mask[3:0] : 4'b0000;
        end
        StAcc1: begin
          rd_en     = ~we_q;
          wr_en     = we_q;
          addr      = word_addr + ADDR_W'(1);
          wr_data   = st_aligned[63:32];
          wr_strobe = we_q ? mask[7:4] : 4'b0000;
        end
        StResp: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
          resp_rdata = (we_q || err_q) ? '0 : ld_result;
        end
        default: ;
      endcase
    end
  end

endmodule
